// File: rtl/carregador_pkg.sv
// Shared definitions for the instruction RAM loader.
//   estado_t          loader FSM states
//   SLOT_SIZE_PADRAO  default words per program slot
//   NUM_SLOTS_PADRAO  default number of program slots
//   SLOT_ROTINA       slot holding the context-switch routine
//   SLOT_SO           slot holding the operating system
//   parametros_validos  accepts/rejects a slot/length request
package carregador_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    RECEBE   = 3'd1,
    ESCREVE  = 3'd2,
    VERIFICA = 3'd3,
    FIM      = 3'd4
  } estado_t;

  localparam int SLOT_SIZE_PADRAO = 200;
  localparam int NUM_SLOTS_PADRAO = 10;
  localparam int SLOT_ROTINA      = 0;
  localparam int SLOT_SO          = 1;

  function automatic logic parametros_validos(input logic [3:0] s,
                                              input logic [7:0] t,
                                              input int         num_slots,
                                              input int         slot_size);
    return (int'(s) < num_slots) && (t != 8'd0) && (int'(t) <= slot_size);
  endfunction

endpackage

// File: rtl/carregador_instrucoes_empacotador.sv
// empacotador_bytes: packs a byte stream into big-endian words.
//   clock, reset_n    clock and synchronous active-low reset
//   limpar            clears the partial word and byte counter
//   aceita            a byte is being taken this cycle
//   byte_in           stream byte
//   palavra_completa  current partial word with byte_in shifted in
//   word_pronto       aceita on the last byte of a word
module empacotador_bytes #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  limpar,
  input  logic                  aceita,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] palavra_completa,
  output logic                  word_pronto
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_WIDTH-1:0] palavra;
  logic [CNT_W-1:0]      contador;

  // First byte of a word ends up in the MSB after BYTES shifts.
  assign palavra_completa = {palavra[DATA_WIDTH-9:0], byte_in};
  assign word_pronto      = aceita && (contador == CNT_W'(BYTES - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      palavra  <= '0;
      contador <= '0;
    end else if (limpar) begin
      palavra  <= '0;
      contador <= '0;
    end else if (aceita) begin
      palavra  <= palavra_completa;
      contador <= word_pronto ? '0 : contador + 1'b1;
    end
  end

endmodule

// File: rtl/carregador_instrucoes.sv
// carregador_instrucoes: write-side loader for the instruction RAM.
// Receives a byte stream (valid/ready), packs it into big-endian words
// and writes them into one program slot (slot*SLOT_SIZE .. +tamanho-1).
// Optional feature macro: CARREGADOR_CHECKSUM_EN (trailing sum word check).
//   clock, reset_n         clock, synchronous active-low reset
//   iniciar, slot, tamanho start request, target slot, length in words
//   byte_in, byte_valido   stream input
//   byte_pronto            loader takes a byte this cycle
//   mem_we, mem_endereco, mem_dado  RAM write port
//   ocupado, concluido, erro        status
//
// state    | meaning
// OCIOSO   | idle, waits for iniciar
// RECEBE   | collects bytes of the current word
// ESCREVE  | writes the assembled word
// VERIFICA | receives the expected sum word (checksum build only)
// FIM      | pulses concluido
module carregador_instrucoes
  import carregador_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SLOT_SIZE  = SLOT_SIZE_PADRAO,
  parameter int NUM_SLOTS  = NUM_SLOTS_PADRAO
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  iniciar,
  input  logic [3:0]            slot,
  input  logic [7:0]            tamanho,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valido,
  output logic                  byte_pronto,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_endereco,
  output logic [DATA_WIDTH-1:0] mem_dado,
  output logic                  ocupado,
  output logic                  concluido,
  output logic                  erro
);

  estado_t               estado, estado_n;
  logic [ADDR_WIDTH-1:0] base;
  logic [7:0]            tamanho_q;
  logic [7:0]            indice;

  logic                  byte_pronto_n, mem_we_n, ocupado_n, concluido_n, erro_n;
  logic [ADDR_WIDTH-1:0] mem_endereco_n;
  logic [DATA_WIDTH-1:0] mem_dado_n;
  logic                  inicio_aceito;

  logic                  aceita;
  logic [DATA_WIDTH-1:0] palavra_completa;
  logic                  word_pronto;

`ifdef CARREGADOR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] soma;
`endif

  assign aceita = byte_valido && byte_pronto;

  empacotador_bytes #(.DATA_WIDTH(DATA_WIDTH)) u_empacotador (
    .clock            (clock),
    .reset_n          (reset_n),
    .limpar           (inicio_aceito),
    .aceita           (aceita),
    .byte_in          (byte_in),
    .palavra_completa (palavra_completa),
    .word_pronto      (word_pronto)
  );

  always_comb begin
    estado_n       = estado;
    inicio_aceito  = 1'b0;
    mem_we_n       = 1'b0;
    mem_endereco_n = '0;
    mem_dado_n     = '0;
    concluido_n    = 1'b0;
    erro_n         = erro;

    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          if (parametros_validos(slot, tamanho, NUM_SLOTS, SLOT_SIZE)) begin
            erro_n        = 1'b0;
            inicio_aceito = 1'b1;
            estado_n      = RECEBE;
          end else begin
            erro_n      = 1'b1;
            concluido_n = 1'b1;
          end
        end
      end
      RECEBE: begin
        // Write port is registered: address/data are set up on the last
        // byte handshake so they appear together with mem_we in ESCREVE.
        if (word_pronto) begin
          estado_n       = ESCREVE;
          mem_we_n       = 1'b1;
          mem_endereco_n = base + ADDR_WIDTH'(indice);
          mem_dado_n     = palavra_completa;
        end
      end
      ESCREVE: begin
        if (indice + 8'd1 == tamanho_q) begin
`ifdef CARREGADOR_CHECKSUM_EN
          estado_n = VERIFICA;
`else
          estado_n = FIM;
`endif
        end else begin
          estado_n = RECEBE;
        end
      end
`ifdef CARREGADOR_CHECKSUM_EN
      VERIFICA: begin
        if (word_pronto) begin
          estado_n = FIM;
          if (palavra_completa != soma) erro_n = 1'b1;
        end
      end
`endif
      FIM:     estado_n = OCIOSO;
      default: estado_n = OCIOSO;
    endcase

    byte_pronto_n = (estado_n == RECEBE) || (estado_n == VERIFICA);
    ocupado_n     = (estado_n != OCIOSO);
    if (estado_n == FIM) concluido_n = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado       <= OCIOSO;
      base         <= '0;
      tamanho_q    <= '0;
      indice       <= '0;
      byte_pronto  <= 1'b0;
      mem_we       <= 1'b0;
      mem_endereco <= '0;
      mem_dado     <= '0;
      ocupado      <= 1'b0;
      concluido    <= 1'b0;
      erro         <= 1'b0;
    end else begin
      estado       <= estado_n;
      byte_pronto  <= byte_pronto_n;
      mem_we       <= mem_we_n;
      mem_endereco <= mem_endereco_n;
      mem_dado     <= mem_dado_n;
      ocupado      <= ocupado_n;
      concluido    <= concluido_n;
      erro         <= erro_n;
      if (inicio_aceito) begin
        base      <= ADDR_WIDTH'(slot) * ADDR_WIDTH'(SLOT_SIZE);
        tamanho_q <= tamanho;
        indice    <= '0;
      end else if (estado == ESCREVE) begin
        indice <= indice + 8'd1;
      end
    end
  end

`ifdef CARREGADOR_CHECKSUM_EN
  // mem_dado holds the word being written during ESCREVE.
  always_ff @(posedge clock) begin
    if (!reset_n)            soma <= '0;
    else if (inicio_aceito)  soma <= '0;
    else if (estado == ESCREVE) soma <= soma + mem_dado;
  end
`endif

endmodule
